// File: rtl/ps2_kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard scan-code sequencer.
// Holds the one-hot parser states, the prefix byte values and the BCD helper.
package ps2_kbd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'b0001,
        ST_EXT     = 4'b0010,
        ST_BRK     = 4'b0100,
        ST_EXT_BRK = 4'b1000
    } state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } evt_t;

    // Two-digit BCD increment; 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r[3:0] = 4'd0;
            r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
        end else begin
            r[7:4] = v[7:4];
            r[3:0] = v[3:0] + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_kbd_ctrl_if.sv
// Byte-in / event-out bundle of the scan-code sequencer.
// slave is the sequencer itself; master is the receiver/consumer side.
interface ps2_kbd_ctrl_if;
    import ps2_kbd_pkg::*;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic [7:0] key_ascii;
    logic [7:0] press_cnt;
    logic       err;

    modport master (
        output rx_data, rx_valid, evt_ready,
        input  rx_ready, evt_valid, evt_code, evt_ext, evt_break,
               key_valid, key_code, key_ext, key_ascii, press_cnt, err
    );

    modport slave (
        input  rx_data, rx_valid, evt_ready,
        output rx_ready, evt_valid, evt_code, evt_ext, evt_break,
               key_valid, key_code, key_ext, key_ascii, press_cnt, err
    );

endinterface

// File: rtl/ps2_scan2ascii.sv
// Combinational set-2 scan code to ASCII lookup: lowercase letters, main-row
// digits and space; anything else yields 0.
module ps2_scan2ascii (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = 8'h61;  8'h32: ascii = 8'h62;  8'h21: ascii = 8'h63;
            8'h23: ascii = 8'h64;  8'h24: ascii = 8'h65;  8'h2B: ascii = 8'h66;
            8'h34: ascii = 8'h67;  8'h33: ascii = 8'h68;  8'h43: ascii = 8'h69;
            8'h3B: ascii = 8'h6A;  8'h42: ascii = 8'h6B;  8'h4B: ascii = 8'h6C;
            8'h3A: ascii = 8'h6D;  8'h31: ascii = 8'h6E;  8'h44: ascii = 8'h6F;
            8'h4D: ascii = 8'h70;  8'h15: ascii = 8'h71;  8'h2D: ascii = 8'h72;
            8'h1B: ascii = 8'h73;  8'h2C: ascii = 8'h74;  8'h3C: ascii = 8'h75;
            8'h2A: ascii = 8'h76;  8'h1D: ascii = 8'h77;  8'h22: ascii = 8'h78;
            8'h35: ascii = 8'h79;  8'h1A: ascii = 8'h7A;
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            8'h29: ascii = 8'h20;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 scan-code sequencer: parses E0/F0 prefixes, tracks the held key,
// drops typematic repeats, counts presses in BCD and emits make/break events.
module ps2_kbd_ctrl
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int TO_W        = 20
) (
    input  logic          clk,
    input  logic          rst,
    ps2_kbd_ctrl_if.slave bus
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t          state_reg, state_next;
    logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
    evt_t            evt_reg, evt_next;
    logic            evt_valid_reg, evt_valid_next;
    logic            key_valid_reg, key_valid_next;
    logic [7:0]      key_code_reg, key_code_next;
    logic            key_ext_reg, key_ext_next;
    logic [7:0]      press_cnt_reg, press_cnt_next;
    logic            err_reg, err_next;

    logic       rx_ready;
    logic       accept;
    logic       do_make;
    logic       do_brk;
    logic       ext_bit;
    logic       key_match;
    logic [7:0] lut_ascii;

    assign rx_ready  = ~evt_valid_reg | bus.evt_ready;
    assign accept    = bus.rx_valid & rx_ready;
    assign key_match = key_valid_reg && (key_ext_reg == ext_bit) && (key_code_reg == bus.rx_data);

    always_comb begin
        state_next     = state_reg;
        to_cnt_next    = to_cnt_reg;
        evt_next       = evt_reg;
        evt_valid_next = evt_valid_reg & ~bus.evt_ready;
        key_valid_next = key_valid_reg;
        key_code_next  = key_code_reg;
        key_ext_next   = key_ext_reg;
        press_cnt_next = press_cnt_reg;
        err_next       = 1'b0;
        do_make        = 1'b0;
        do_brk         = 1'b0;
        ext_bit        = 1'b0;

        if (accept) begin
            to_cnt_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus.rx_data == PS2_EXT)      state_next = ST_EXT;
                    else if (bus.rx_data == PS2_BRK) state_next = ST_BRK;
                    else                             do_make = 1'b1;
                end
                ST_EXT: begin
                    if (bus.rx_data == PS2_BRK) begin
                        state_next = ST_EXT_BRK;
                    end else if (bus.rx_data == PS2_EXT) begin
                        err_next = 1'b1;
                    end else begin
                        do_make    = 1'b1;
                        ext_bit    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    ext_bit    = (state_reg == ST_EXT_BRK);
                    state_next = ST_IDLE;
                    if (bus.rx_data == PS2_EXT || bus.rx_data == PS2_BRK) err_next = 1'b1;
                    else                                                   do_brk   = 1'b1;
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state_reg != ST_IDLE) begin
            // A stalled prefix is abandoned so a lost byte cannot wedge the parser.
            if (to_cnt_reg == TO_LAST) begin
                err_next    = 1'b1;
                state_next  = ST_IDLE;
                to_cnt_next = '0;
            end else begin
                to_cnt_next = to_cnt_reg + 1'b1;
            end
        end else begin
            to_cnt_next = '0;
        end

        if (do_make && !key_match) begin
            key_valid_next = 1'b1;
            key_code_next  = bus.rx_data;
            key_ext_next   = ext_bit;
            press_cnt_next = bcd_inc(press_cnt_reg);
            evt_valid_next = 1'b1;
            evt_next       = '{code: bus.rx_data, ext: ext_bit, brk: 1'b0};
        end

        if (do_brk) begin
            evt_valid_next = 1'b1;
            evt_next       = '{code: bus.rx_data, ext: ext_bit, brk: 1'b1};
            if (key_match) begin
                key_valid_next = 1'b0;
                key_code_next  = 8'h00;
                key_ext_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            to_cnt_reg    <= '0;
            evt_reg       <= '0;
            evt_valid_reg <= 1'b0;
            key_valid_reg <= 1'b0;
            key_code_reg  <= 8'h00;
            key_ext_reg   <= 1'b0;
            press_cnt_reg <= 8'h00;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            to_cnt_reg    <= to_cnt_next;
            evt_reg       <= evt_next;
            evt_valid_reg <= evt_valid_next;
            key_valid_reg <= key_valid_next;
            key_code_reg  <= key_code_next;
            key_ext_reg   <= key_ext_next;
            press_cnt_reg <= press_cnt_next;
            err_reg       <= err_next;
        end
    end

    ps2_scan2ascii u_scan2ascii (
        .code  (key_code_reg),
        .ascii (lut_ascii)
    );

    assign bus.rx_ready  = rx_ready;
    assign bus.evt_valid = evt_valid_reg;
    assign bus.evt_code  = evt_reg.code;
    assign bus.evt_ext   = evt_reg.ext;
    assign bus.evt_break = evt_reg.brk;
    assign bus.key_valid = key_valid_reg;
    assign bus.key_code  = key_code_reg;
    assign bus.key_ext   = key_ext_reg;
    assign bus.key_ascii = key_ext_reg ? 8'h00 : lut_ascii;
    assign bus.press_cnt = press_cnt_reg;
    assign bus.err       = err_reg;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: expected events are queued as bytes are
// driven and compared when the event handshake completes.
module tb_ps2_kbd_ctrl;
    import ps2_kbd_pkg::*;

    localparam int TO_CYC = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    ps2_kbd_ctrl_if bus();

    ps2_kbd_ctrl #(.TIMEOUT_CYC(TO_CYC), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   vec_cnt     = 0;
    int   miscompares = 0;
    int   err_cnt     = 0;
    evt_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Event monitor: handshake completes at the following rising edge.
    always @(negedge clk) begin
        evt_t got_evt;
        evt_t exp_evt;
        if (rst && bus.err) err_cnt++;
        if (rst && bus.evt_valid && bus.evt_ready) begin
            got_evt = '{code: bus.evt_code, ext: bus.evt_ext, brk: bus.evt_break};
            $display("evt code=%h ext=%b brk=%b", got_evt.code, got_evt.ext, got_evt.brk);
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_evt = exp_q.pop_front();
                chk("evt", 32'(got_evt), 32'(exp_evt));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 unit after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int   n = 0;
        logic ok;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        do begin
            @(negedge clk);
            ok = bus.rx_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        bus.rx_valid = 1'b0;
        if (!ok) chk("rx_stall", 32'(ok), 32'd1);
    endtask

    task automatic push_evt(input logic [7:0] code, input logic ext, input logic brk);
        exp_q.push_back('{code: code, ext: ext, brk: brk});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick(1);
            n++;
        end
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    initial begin
        int       e0;
        int       n;
        logic [7:0] exp_bcd;

        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.evt_ready = 1'b0;
        #23;
        chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_evt_code",  32'(bus.evt_code),  32'd0);
        chk("rst_key_valid", 32'(bus.key_valid), 32'd0);
        chk("rst_key_code",  32'(bus.key_code),  32'd0);
        chk("rst_press_cnt", 32'(bus.press_cnt), 32'd0);
        chk("rst_err",       32'(bus.err),       32'd0);
        chk("rst_rx_ready",  32'(bus.rx_ready),  32'd1);
        rst = 1'b1;
        tick(1);

        // Make then break of 'a'
        bus.evt_ready = 1'b1;
        push_evt(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        chk("mk_evt_valid", 32'(bus.evt_valid), 32'd1);
        chk("mk_key_valid", 32'(bus.key_valid), 32'd1);
        chk("mk_key_code",  32'(bus.key_code),  32'h1C);
        chk("mk_key_ascii", 32'(bus.key_ascii), 32'h61);
        chk("mk_press_cnt", 32'(bus.press_cnt), 32'h01);
        send_byte(8'hF0);
        chk("f0_key_valid", 32'(bus.key_valid), 32'd1);
        push_evt(8'h1C, 1'b0, 1'b1);
        send_byte(8'h1C);
        chk("bk_key_valid", 32'(bus.key_valid), 32'd0);
        chk("bk_key_code",  32'(bus.key_code),  32'd0);
        chk("bk_key_ascii", 32'(bus.key_ascii), 32'd0);
        chk("bk_press_cnt", 32'(bus.press_cnt), 32'h01);
        drain();
        do_reset();

        // Typematic repeat suppression
        push_evt(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        chk("rep_press_cnt", 32'(bus.press_cnt), 32'h01);
        push_evt(8'h1C, 1'b0, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("rep_press_cnt2", 32'(bus.press_cnt), 32'h01);
        chk("rep_key_valid",  32'(bus.key_valid), 32'd0);
        drain();
        do_reset();

        // Extended key under backpressure
        bus.evt_ready = 1'b0;
        send_byte(8'hE0);
        push_evt(8'h75, 1'b1, 1'b0);
        send_byte(8'h75);
        chk("ext_evt_valid", 32'(bus.evt_valid), 32'd1);
        chk("ext_evt_code",  32'(bus.evt_code),  32'h75);
        chk("ext_evt_ext",   32'(bus.evt_ext),   32'd1);
        chk("ext_evt_break", 32'(bus.evt_break), 32'd0);
        chk("ext_rx_ready",  32'(bus.rx_ready),  32'd0);
        chk("ext_key_ext",   32'(bus.key_ext),   32'd1);
        chk("ext_key_ascii", 32'(bus.key_ascii), 32'd0);
        fork
            send_byte(8'hE0);
            begin
                tick(5);
                chk("bp_evt_valid", 32'(bus.evt_valid), 32'd1);
                chk("bp_rx_ready",  32'(bus.rx_ready),  32'd0);
                bus.evt_ready = 1'b1;
            end
        join
        push_evt(8'h75, 1'b1, 1'b1);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("extbk_key_valid", 32'(bus.key_valid), 32'd0);
        chk("extbk_key_ascii", 32'(bus.key_ascii), 32'd0);
        drain();
        do_reset();

        // BCD press counter wrap
        for (int i = 0; i < 100; i++) begin
            logic [7:0] code;
            code = (i % 2 == 1) ? 8'h32 : 8'h1C;
            push_evt(code, 1'b0, 1'b0);
            send_byte(code);
            n = (i + 1) % 100;
            exp_bcd = {4'(n / 10), 4'(n % 10)};
            chk("wrap_press_cnt", 32'(bus.press_cnt), 32'(exp_bcd));
            if (i == 1) chk("wrap_ascii_b", 32'(bus.key_ascii), 32'h62);
        end
        drain();
        do_reset();

        // Protocol errors: double break prefix, double extended prefix
        e0 = err_cnt;
        send_byte(8'hF0);
        send_byte(8'hF0);
        tick(2);
        chk("ff_err_pulses", 32'(err_cnt - e0), 32'd1);
        push_evt(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        e0 = err_cnt;
        send_byte(8'hE0);
        send_byte(8'hE0);
        tick(2);
        chk("ee_err_pulses", 32'(err_cnt - e0), 32'd1);
        push_evt(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        chk("ee_key_ext",   32'(bus.key_ext),   32'd1);
        chk("ee_key_ascii", 32'(bus.key_ascii), 32'd0);

        // Prefix timeout
        e0 = err_cnt;
        send_byte(8'hE0);
        tick(TO_CYC + 5);
        chk("to_err_pulses", 32'(err_cnt - e0), 32'd1);
        push_evt(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        chk("to_key_ext", 32'(bus.key_ext), 32'd0);

        // Byte arriving on the timeout cycle wins
        e0 = err_cnt;
        send_byte(8'hE0);
        repeat (TO_CYC - 1) @(posedge clk);
        #1;
        push_evt(8'h1C, 1'b1, 1'b0);
        send_byte(8'h1C);
        tick(2);
        chk("to_edge_err", 32'(err_cnt - e0), 32'd0);
        chk("to_edge_key_ext", 32'(bus.key_ext), 32'd1);
        drain();
        do_reset();

        // Asynchronous reset while in BRK
        push_evt(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        send_byte(8'hF0);
        drain();
        #2 rst = 1'b0;
        #1;
        chk("arst_key_valid", 32'(bus.key_valid), 32'd0);
        chk("arst_key_code",  32'(bus.key_code),  32'd0);
        chk("arst_press_cnt", 32'(bus.press_cnt), 32'd0);
        #2 rst = 1'b1;
        tick(1);
        push_evt(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        chk("arst_mk_press", 32'(bus.press_cnt), 32'h01);
        drain();

        // Asynchronous reset with an event pending
        bus.evt_ready = 1'b0;
        send_byte(8'h2A);
        chk("pend_evt_valid", 32'(bus.evt_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("arst_evt_code",  32'(bus.evt_code),  32'd0);
        chk("arst_key_valid2", 32'(bus.key_valid), 32'd0);
        chk("arst_rx_ready",  32'(bus.rx_ready),  32'd1);
        #2 rst = 1'b1;
        tick(1);
        bus.evt_ready = 1'b1;
        tick(3);

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_ctrl.md
# ps2_kbd_ctrl

Scan-code sequencer between the PS/2 byte receiver and the display/CPU side. It pulls raw bytes from the receiver with a valid/ready handshake and parses the E0 (extended) and F0 (break) prefixes. It tracks the currently held key, suppresses typematic repeats and counts distinct presses in BCD. Decoded make/break events go out through a one-entry valid/ready event register.

## Interface

Parameters:
- TIMEOUT_CYC, 1_000_000: cycles without a new byte before a pending prefix state is abandoned.
- TO_W, 20: width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rx_data  in  8  byte from the PS/2 receiver.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  byte accepted when rx_valid && rx_ready.
- evt_valid  out  1  event register full.
- evt_ready  in  1  downstream takes the event when evt_valid && evt_ready.
- evt_code  out  8  scan code of the event.
- evt_ext  out  1  event had the E0 prefix.
- evt_break  out  1  1 = break (release), 0 = make (press).
- key_valid  out  1  a key is currently held.
- key_code  out  8  held key scan code; 0 when none is held.
- key_ext  out  1  held key is extended.
- key_ascii  out  8  ASCII of key_code; 0 when unmapped or key_ext = 1.
- press_cnt  out  8  two BCD digits counting distinct presses.
- err  out  1  one-cycle protocol error pulse.

## Operation

- Reset values:
  - Parser state is IDLE.
  - evt_valid, evt_code, evt_ext and evt_break are 0.
  - key_valid, key_code and key_ext are 0; press_cnt is 8'h00.
  - err is 0; the timeout counter is 0.
  - Reset applied mid-sequence discards any pending prefix and event.
- rx_ready = ~evt_valid | evt_ready. This is combinational; the block never drops a byte.
- Parser FSM, one-hot states IDLE, EXT, BRK, EXT_BRK. Transitions happen only on an accepted byte b:
  - IDLE: b = E0 goes to EXT. b = F0 goes to BRK. Any other b is a make(b, ext=0), and the state stays IDLE.
  - EXT: b = F0 goes to EXT_BRK. b = E0 pulses err and stays in EXT. Any other b is a make(b, ext=1), then IDLE.
  - BRK: b = E0 or F0 pulses err and returns to IDLE. Any other b is a break(b, ext=0), then IDLE.
  - EXT_BRK: b = E0 or F0 pulses err and returns to IDLE. Any other b is a break(b, ext=1), then IDLE.
- Make(c, x):
  - If key_valid and {key_ext, key_code} == {x, c}, it is a typematic repeat: no event, no count, held key unchanged.
  - Otherwise the held key becomes {x, c} with key_valid = 1, press_cnt increments in BCD, and an event loads with evt_break = 0.
  - BCD increment: low digit 9 becomes 0 with a carry; 99 wraps to 00.
- Break(c, x):
  - An event always loads, with evt_break = 1.
  - If it matches the held key, key_valid, key_code and key_ext clear to 0.
  - A break for a different key leaves the held key unchanged.
- Event register:
  - It loads on the accepted byte that completes an event and holds until the evt handshake.
  - Same-cycle evt handshake plus a new completing byte: the new event replaces the old one and evt_valid stays 1.
- Timeout:
  - The counter runs only in EXT, BRK or EXT_BRK and clears on every accepted byte.
  - On reaching TIMEOUT_CYC-1 it pulses err, returns to IDLE and clears.
  - An accepted byte in that same cycle takes priority: normal transition, no err.

## Timing

- Byte accepted in cycle N: state, held key, press_cnt, the event register and err are all updated at the edge ending cycle N and visible in N+1.
- Make/break latency is 1 cycle from the completing byte; prefix bytes produce no output.
- Throughput is one byte per cycle while the event sink is ready.
- key_ascii is combinational from key_code and key_ext, with no added latency.
- err is high for exactly one cycle per error.

## Structure

- Package ps2_kbd_pkg holds:
  - the state one-hot encodings;
  - PS2_EXT = 8'hE0 and PS2_BRK = 8'hF0;
  - a BCD increment function.
- Sub-module ps2_scan2ascii is a combinational lookup of set-2 codes to ASCII:
  - letters a–z are lowercase;
  - digits 0–9 on the main row;
  - space is 8'h29;
  - everything else maps to 0.

## Test plan

- Make/break sequence:
  - Stimulus: bytes 1C, F0, 1C with evt_ready = 1.
  - Response: event {1C, make}, then event {1C, break}. key_valid is 1 after the make with key_ascii = 8'h61, then 0. press_cnt = 01.
- Typematic repeat:
  - Stimulus: bytes 1C, 1C, 1C, F0, 1C.
  - Response: only one make event and one break event; press_cnt = 01.
- Extended key with backpressure:
  - Stimulus: bytes E0, 75, E0, F0, 75 with evt_ready = 0 after the first event.
  - Response: evt_valid holds {75, ext, make} and rx_ready = 0. After evt_ready rises, the break arrives with ext = 1. key_ascii = 0 throughout.
- Counter wrap:
  - Stimulus: 100 distinct alternating makes, 1C and 32.
  - Response: press_cnt reaches 99 and then 00.
- Errors:
  - Stimulus: bytes F0, F0.
  - Response: err pulses on the second byte and the state is IDLE.
  - Stimulus: E0, then no byte for TIMEOUT_CYC cycles.
  - Response: a single err pulse and IDLE; a following 1C is treated as a non-extended make.
- Reset:
  - Stimulus: rst asserted during BRK with an event pending.
  - Response: all outputs return to their reset values immediately (asynchronously).
